// File: rtl/unpacker.sv
// Word-to-byte width converter: pops one word from the read-side word FIFO and
// writes it into the byte FIFO least-significant byte first.
module unpacker #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_empty,
    output logic                  word_rd_en,
    input  logic                  byte_fifo_full,
    output logic [DATA_WIDTH-1:0] byte_out,
    output logic                  byte_wr,
    output logic                  busy,
    output logic [15:0]           words_done
);
    localparam int BYTES = WORD_WIDTH / DATA_WIDTH;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } state_e;

    state_e                state_q;
    logic [WORD_WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [15:0]           words_done_q;

    // Strobes are gated by rst_n so nothing reaches either FIFO while reset is held.
    assign word_rd_en = rst_n && (state_q == IDLE) && !word_empty;
    assign byte_wr    = rst_n && (state_q == EMIT) && !byte_fifo_full;
    assign byte_out   = shreg_q[DATA_WIDTH-1:0];
    assign busy       = (state_q != IDLE);
    assign words_done = words_done_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            // NOTE: the wide shift register is reset on purpose so byte_out reads 0
            // out of reset; it is a datapath register, not a memory array.
            shreg_q      <= '0;
            cnt_q        <= '0;
            words_done_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (word_rd_en) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    shreg_q <= word_in;
                    cnt_q   <= '0;
                    state_q <= EMIT;
                end
                EMIT: begin
                    // A stalled byte keeps shreg, cnt and state frozen until the FIFO drains.
                    if (byte_wr) begin
                        shreg_q <= shreg_q >> DATA_WIDTH;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            words_done_q <= words_done_q + 16'd1;
                            state_q      <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unpacker.sv
// Self-checking bench for unpacker: a word-FIFO model feeds the DUT and a byte
// scoreboard derived from popped words checks every committed byte.
module tb_unpacker;
    localparam int DW    = 8;
    localparam int WW    = 256;
    localparam int BYTES = WW / DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WW-1:0] word_in;
    logic          word_empty;
    logic          word_rd_en;
    logic          byte_fifo_full;
    logic [DW-1:0] byte_out;
    logic          byte_wr;
    logic          busy;
    logic [15:0]   words_done;

    unpacker #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .word_in        (word_in),
        .word_empty     (word_empty),
        .word_rd_en     (word_rd_en),
        .byte_fifo_full (byte_fifo_full),
        .byte_out       (byte_out),
        .byte_wr        (byte_wr),
        .busy           (busy),
        .words_done     (words_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic [WW-1:0] wq[$];       // word FIFO contents
    exp_t          exp_q[$];    // bytes still owed by the DUT
    logic [DW-1:0] out_log[$];  // every committed byte
    int            rd_cyc[$];
    int            wr_cyc[$];
    logic [WW-1:0] pend;
    logic          pend_valid = 1'b0;
    logic          in_flight  = 1'b0;
    logic          synced     = 1'b0;
    logic          prev_rst_low = 1'b0;
    logic [15:0]   wd_exp = '0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, sample, update the model.
    task automatic cycle(input logic rst_v, input logic full_v, input logic gate_v);
        exp_t e;
        @(negedge clk);
        rst_n          = rst_v;
        byte_fifo_full = full_v;
        word_empty     = gate_v || (wq.size() == 0);
        word_in        = pend_valid ? pend : {8{$urandom()}};
        pend_valid     = 1'b0;
        #1;
        if (prev_rst_low) begin
            check("post_rst_byte_out", byte_out, 0);
            check("post_rst_busy", busy, 0);
            check("post_rst_words_done", words_done, 0);
        end
        if (!rst_v) begin
            check("rst_word_rd_en", word_rd_en, 0);
            check("rst_byte_wr", byte_wr, 0);
        end else if (synced) begin
            check("word_rd_en", word_rd_en, !in_flight && !word_empty);
            check("busy", busy, in_flight);
            check("words_done", words_done, wd_exp);
            if (full_v) check("byte_wr_when_full", byte_wr, 0);
            if (word_rd_en) begin
                pend       = wq.pop_front();
                pend_valid = 1'b1;
                in_flight  = 1'b1;
                rd_cyc.push_back(cyc);
                for (int k = 0; k < BYTES; k++) exp_q.push_back('{pend[DW*k +: DW], k == BYTES - 1});
            end
            if (byte_wr) begin
                check("byte_owed", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("byte_out", byte_out, e.data);
                    if (e.last) begin
                        wd_exp    = wd_exp + 16'd1;
                        in_flight = 1'b0;
                    end
                end
                out_log.push_back(byte_out);
                wr_cyc.push_back(cyc);
            end
        end
        if (!rst_v) begin
            exp_q.delete();
            in_flight = 1'b0;
            wd_exp    = '0;
            synced    = 1'b1;
        end
        prev_rst_low = !rst_v;
        cyc++;
    endtask

    // Run until the word FIFO is empty and the last word has been fully written.
    task automatic drain(input int max_cyc, input int full_pct, input int empty_pct);
        int n = 0;
        while ((wq.size() != 0 || in_flight) && n < max_cyc) begin
            cycle(1'b1, $urandom_range(99) < full_pct, $urandom_range(99) < empty_pct);
            n++;
        end
        check("drain_timeout", n < max_cyc, 1);
        cycle(1'b1, 1'b0, 1'b1);
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int k = 0; k < WW / 32; k++) w[32*k +: 32] = $urandom();
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] w, wa, wb;
        logic [DW-1:0] lb_in[64];
        int nb0, n, sa, sb, idx, wd0;
        logic f;

        rst_n = 1'b0; word_empty = 1'b1; byte_fifo_full = 1'b0; word_in = '0;

        // Reset with a word waiting, then a single known word with no backpressure.
        for (int k = 0; k < BYTES; k++) w[DW*k +: DW] = DW'(k);
        wq.push_back(w);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        rd_cyc.delete(); wr_cyc.delete(); out_log.delete();
        drain(200, 0, 0);
        check("single_rd_count", rd_cyc.size(), 1);
        check("single_wr_count", wr_cyc.size(), BYTES);
        if (rd_cyc.size() == 1 && wr_cyc.size() == BYTES) begin
            check("single_first_wr_cycle", wr_cyc[0] - rd_cyc[0], 2);
            check("single_last_wr_cycle", wr_cyc[BYTES-1] - rd_cyc[0], BYTES + 1);
            check("single_first_byte", out_log[0], 8'h00);
            check("single_byte_10", out_log[10], 8'h0a);
            check("single_last_byte", out_log[BYTES-1], 8'h1f);
        end
        check("single_idle", busy, 0);
        check("single_words_done", words_done, 1);

        // Backpressure on the 11th and last byte of the first of two queued words.
        rd_cyc.delete(); nb0 = out_log.size(); sa = 0; sb = 0; n = 0;
        wq.push_back(rand_word()); wq.push_back(rand_word());
        while ((wq.size() != 0 || in_flight) && n < 400) begin
            f = 1'b0;
            if (out_log.size() - nb0 == 10 && sa < 5) begin f = 1'b1; sa++; end
            else if (out_log.size() - nb0 == BYTES - 1 && sb < 3) begin f = 1'b1; sb++; end
            cycle(1'b1, f, 1'b0);
            n++;
        end
        check("bp_timeout", n < 400, 1);
        cycle(1'b1, 1'b0, 1'b1);
        check("bp_writes", out_log.size() - nb0, 2 * BYTES);
        check("bp_rd_count", rd_cyc.size(), 2);
        if (rd_cyc.size() == 2) check("bp_refetch_delay", rd_cyc[1] - rd_cyc[0], BYTES + 2 + 5 + 3);
        check("bp_words_done", words_done, 3);

        // Three words back to back: one fetch every BYTES+2 cycles.
        rd_cyc.delete(); nb0 = out_log.size();
        repeat (3) wq.push_back(rand_word());
        drain(400, 0, 0);
        check("b2b_rd_count", rd_cyc.size(), 3);
        if (rd_cyc.size() == 3) begin
            check("b2b_rd_gap1", rd_cyc[1] - rd_cyc[0], BYTES + 2);
            check("b2b_rd_gap2", rd_cyc[2] - rd_cyc[0], 2 * (BYTES + 2));
        end
        check("b2b_writes", out_log.size() - nb0, 3 * BYTES);
        check("b2b_words_done", words_done, 6);

        // Reset after byte 12 of word A, with word B still queued.
        wa = rand_word(); wb = rand_word();
        wq.push_back(wa); wq.push_back(wb);
        nb0 = out_log.size(); n = 0;
        while (out_log.size() - nb0 < 12 && n < 100) begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end
        check("mid_a_bytes", out_log.size() - nb0, 12);
        idx = out_log.size();
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        check("mid_no_writes_in_reset", out_log.size() - idx, 0);
        check("mid_words_done_reset", words_done, 0);
        drain(200, 0, 0);
        check("mid_b_writes", out_log.size() - idx, BYTES);
        if (out_log.size() > idx) check("mid_first_after_reset", out_log[idx], wb[DW-1:0]);
        check("mid_words_done", words_done, 1);
        check("mid_fifo_not_reread", wq.size(), 0);

        // Loopback: 64 random bytes packed LSB-first into words, then unpacked.
        nb0 = out_log.size(); wd0 = int'(words_done);
        for (int i = 0; i < 64; i++) lb_in[i] = DW'($urandom_range(255));
        for (int wi = 0; wi < 64 / BYTES; wi++) begin
            for (int k = 0; k < BYTES; k++) w[DW*k +: DW] = lb_in[wi*BYTES + k];
            wq.push_back(w);
        end
        drain(2000, 30, 20);
        check("lb_count", out_log.size() - nb0, 64);
        if (out_log.size() - nb0 == 64) begin
            for (int i = 0; i < 64; i++) check("lb_byte", out_log[nb0 + i], lb_in[i]);
        end
        check("lb_words_done", int'(words_done) - wd0, 2);

        // Random stress with heavy stalls and gaps.
        nb0 = out_log.size(); wd0 = int'(words_done);
        repeat (12) wq.push_back(rand_word());
        drain(4000, 40, 30);
        check("rand_count", out_log.size() - nb0, 12 * BYTES);
        check("rand_words_done", int'(words_done) - wd0, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
